rng_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single `rand_num_gen` instance between several requesters, e.g. the game FSM draw path and the VGA card-flip animation. Each requester raises a level request. The arbiter steps the generator for a fixed number of enable cycles, captures the result and returns it with a one-cycle acknowledge. While no request is pending, the arbiter can free-run the generator to stir its state from user timing.

---
 rtl/rng_arbiter.sv | 134 +++++++++++++
 tb/tb_rng_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sequencer sharing one rand_num_gen between
// several requesters. A grant steps the generator for SETTLE enable cycles,
// captures its output and returns it with a one-cycle one-hot ack.
// While nothing is pending the generator may free-run to stir its state.
module rng_arbiter #(
    parameter int NREQ   = 2,
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic                    idle_spin,
    input  logic [WIDTH-1:0]        rng_val,
    output logic                    rng_enb,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        data,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   idx;
    logic            found;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] eligible;
    logic            any_eligible;

    // A requester whose ack is pulsing this cycle is excluded, so a level
    // request held through its own ack cycle cannot be granted twice.
    assign eligible     = req & ~ack;
    assign any_eligible = |eligible;

    // Round-robin search: first eligible index upward from last+1, wrapping.
    always_comb begin
        winner = last;
        idx    = last;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; idle stirring yields to any
    // pending request so it never delays a grant.
    always_comb begin
        state_nxt = state;
        rng_enb   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                rng_enb = idle_spin & ~any_eligible;
                if (any_eligible) begin
                    state_nxt = STEP;
                end
            end
            STEP: begin
                rng_enb = 1'b1;
                if (cnt == '0) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant latch, step counter, result capture and the one-cycle ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack      <= '0;
            data     <= '0;
            grant_id <= '0;
            last     <= LAST_IDX;
            cnt      <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        grant_id <= winner;
                        last     <= winner;
                        cnt      <= CNT_LOAD;
                    end
                end
                STEP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    data <= rng_val;
                    ack  <= ONE_HOT0 << grant_id;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter. Two instances: A (NREQ=2, SETTLE=1) and
// B (NREQ=3, SETTLE=4). Each drives rng_val from a stand-in generator that
// starts at 0 on reset and adds 8'h13 on every enabled cycle.
module tb_rng_arbiter;

    logic       clk;
    logic       reset_a, reset_b;
    logic [1:0] req_a;
    logic [2:0] req_b;
    logic       spin_a, spin_b;
    logic [7:0] gen_a, gen_b;
    logic       enb_a, enb_b;
    logic [1:0] ack_a;
    logic [2:0] ack_b;
    logic [7:0] data_a, data_b;
    logic       grant_a;
    logic [1:0] grant_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    rng_arbiter #(.NREQ(2), .WIDTH(8), .SETTLE(1)) u_dut_a (
        .clk(clk), .reset(reset_a), .req(req_a), .idle_spin(spin_a),
        .rng_val(gen_a), .rng_enb(enb_a), .ack(ack_a), .data(data_a),
        .grant_id(grant_a), .busy(busy_a)
    );

    rng_arbiter #(.NREQ(3), .WIDTH(8), .SETTLE(4)) u_dut_b (
        .clk(clk), .reset(reset_b), .req(req_b), .idle_spin(spin_b),
        .rng_val(gen_b), .rng_enb(enb_b), .ack(ack_b), .data(data_b),
        .grant_id(grant_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in generator for instance A.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) gen_a <= 8'h00;
        else if (enb_a) gen_a <= gen_a + 8'h13;
    end

    // Stand-in generator for instance B.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) gen_b <= 8'h00;
        else if (enb_b) gen_b <= gen_b + 8'h13;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        req_a = '0; req_b = '0; spin_a = 1'b0; spin_b = 1'b0;
        cyc(); cyc(); #1;
        check("rst_ack_a", ack_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_grant_a", grant_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_enb_a", enb_a, 0);
        check("rst_busy_b", busy_b, 0);
        reset_a = 1'b0; reset_b = 1'b0;

        // Single draw on A: enable in cycle 1 only, ack in cycle 3.
        cyc(); req_a = 2'b01; #1;
        check("t1_enb_c0", enb_a, 0);
        cyc(); #1;
        check("t1_busy_c1", busy_a, 1);
        check("t1_enb_c1", enb_a, 1);
        check("t1_grant_c1", grant_a, 0);
        cyc(); #1;
        check("t1_enb_c2", enb_a, 0);
        check("t1_ack_c2", ack_a, 0);
        cyc(); #1;
        check("t1_ack_c3", ack_a, 2'b01);
        check("t1_data_c3", data_a, 8'h13);
        req_a = 2'b00; #1;
        check("t1_busy_c3", busy_a, 0);
        check("t1_enb_c3", enb_a, 0);
        cyc(); #1;
        check("t1_ack_c4", ack_a, 0);
        check("t1_data_hold", data_a, 8'h13);

        // Contention from reset: grants alternate 0,1,0,1 every 3 cycles.
        reset_a = 1'b1; #1; reset_a = 1'b0;
        req_a = 2'b11;
        for (int g = 0; g < 4; g++) begin
            cyc(); #1;
            check("t2_grant", grant_a, g % 2);
            check("t2_busy", busy_a, 1);
            cyc(); cyc(); #1;
            check("t2_ack", ack_a, 32'd1 << (g % 2));
            check("t2_data", data_a, (32'h13 * (g + 1)) & 32'hFF);
        end
        req_a = 2'b00;
        cyc(); #1;
        check("t2_idle_busy", busy_a, 0);
        check("t2_idle_ack", ack_a, 0);

        // No double grant: req[0] still high during its ack cycle.
        req_a = 2'b01;
        cyc(); cyc(); cyc(); #1;
        check("t3_ack", ack_a, 2'b01);
        check("t3_data", data_a, 8'h5F);
        #1;
        req_a = 2'b00;
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            check("t3_no_reack", ack_a, 0);
            check("t3_idle_busy", busy_a, 0);
        end

        // Idle stirring for 10 cycles, then a request for index 1.
        spin_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t4_spin_enb", enb_a, 1);
            cyc();
        end
        req_a = 2'b10; #1;
        check("t4_req_enb", enb_a, 0);
        cyc(); #1;
        check("t4_step_enb", enb_a, 1);
        check("t4_grant", grant_a, 1);
        cyc(); #1;
        check("t4_cap_enb", enb_a, 0);
        cyc(); #1;
        check("t4_ack", ack_a, 2'b10);
        check("t4_data", data_a, 8'h30);
        req_a = 2'b00; #1;
        check("t4_spin_resume", enb_a, 1);
        spin_a = 1'b0;

        // Dropped request: one-cycle pulse on req[1] still completes.
        cyc();
        reset_a = 1'b1; #1; reset_a = 1'b0;
        req_a = 2'b10;
        cyc(); req_a = 2'b00; #1;
        check("t6_busy", busy_a, 1);
        check("t6_grant", grant_a, 1);
        cyc(); #1;
        check("t6_ack_cap", ack_a, 0);
        cyc(); #1;
        check("t6_ack", ack_a, 2'b10);
        check("t6_data", data_a, 8'h13);
        cyc(); #1;
        check("t6_ack_off", ack_a, 0);
        check("t6_busy_off", busy_a, 0);

        // Reset in the second STEP cycle of B discards the draw.
        req_b = 3'b001;
        cyc(); #1;
        check("t5_step1_enb", enb_b, 1);
        cyc(); #1;
        reset_b = 1'b1; #1;
        check("t5_rst_ack", ack_b, 0);
        check("t5_rst_busy", busy_b, 0);
        check("t5_rst_enb", enb_b, 0);
        check("t5_rst_grant", grant_b, 0);
        check("t5_rst_data", data_b, 0);
        cyc(); #1;
        check("t5_rst_ack2", ack_b, 0);
        check("t5_rst_busy2", busy_b, 0);
        reset_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(); #1;
            check("t5_no_ack", ack_b, 0);
            check("t5_busy", busy_b, 1);
        end
        cyc(); #1;
        check("t5_ack", ack_b, 3'b001);
        check("t5_data", data_b, 8'h4C);

        // Fairness on B with three requesters permanently requesting.
        req_b = 3'b111;
        for (int g = 0; g < 6; g++) begin
            cyc(); #1;
            check("t7_grant", grant_b, (g + 1) % 3);
            check("t7_busy", busy_b, 1);
            cyc(); cyc(); cyc(); cyc(); cyc(); #1;
            check("t7_ack", ack_b, 32'd1 << ((g + 1) % 3));
            check("t7_data", data_b, (32'h4C * (g + 2)) & 32'hFF);
        end
        req_b = 3'b000;
        cyc(); #1;
        check("t7_idle", busy_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
